// File: rtl/port_arbiter_pkg.sv
// port_arbiter_pkg: shared constants, control FSM encoding and the id-width
// helper used by the arbiter, its interface and the round-robin picker.
package port_arbiter_pkg;

  localparam int DEFAULT_NREQ = 4;
  localparam int DEFAULT_DW   = 16;

  // Control FSM: IDLE = output register empty, FULL = output register holds
  // a word, LOCK = a burst is open and the grant is pinned to its owner.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_FULL = 2'd1,
    ARB_LOCK = 2'd2
  } arb_state_e;

  // Flat constants for code that keeps the state in a plain logic vector.
  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_FULL = ARB_FULL;
  localparam logic [1:0] ST_LOCK = ARB_LOCK;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// port_arbiter_if: requester-side and output-side handshake bundle.
// master = the arbiter itself, slave = the surrounding requesters/sink.
interface port_arbiter_if
  import port_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int DW   = DEFAULT_DW
);

  localparam int IW = id_width(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;

  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_id;
  logic               out_ready;

  modport master (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

  modport slave (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/port_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin picker. Scans the request
// vector starting at 'start', wrapping past NREQ-1, and returns the first
// active requester as both a one-hot grant and an index.
module rr_pick
  import port_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int            pos;
  logic [IW-1:0] ci;

  // Walk the requesters in priority order from start and keep the first hit.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    ci  = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(start) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      ci = IW'(pos);
      if (!any && req[ci]) begin
        any     = 1'b1;
        idx     = ci;
        gnt[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: NREQ-to-1 round-robin arbiter feeding a single registered
// output word with valid/ready handshake and a clock enable.
// Optional burst locking is enabled by defining PORT_ARBITER_LOCK_EN; when it
// is undefined req_last is ignored and every word is arbitrated on its own.
// clr_n asserts asynchronously; its release is expected to arrive already
// synchronised to clk by the system reset-release path, so a grant can
// happen on the very first edge after release.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int DW   = DEFAULT_DW
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           ce,
  port_arbiter_if.master bus
);

  localparam int              IW       = id_width(NREQ);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [IW-1:0]   last_grant;

  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic [IW-1:0]   out_id_q;

  logic            free;
  logic            xfer;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic [IW-1:0]   rr_start;

  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_start;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  // Fair search starts one past whoever last completed a transfer.
  always_comb begin
    rr_start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
  end

`ifdef PORT_ARBITER_LOCK_EN
  // During an open burst only its owner is eligible; otherwise plain round-robin.
  always_comb begin
    if (state == ST_LOCK) begin
      pick_req   = bus.req_valid & (NREQ'(1) << last_grant);
      pick_start = last_grant;
    end else begin
      pick_req   = bus.req_valid;
      pick_start = rr_start;
    end
  end

  assign sel_last = bus.req_last[pick_idx];
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;

  // Without locking every word competes independently.
  always_comb begin
    pick_req   = bus.req_valid;
    pick_start = rr_start;
  end

  assign sel_last = 1'b1;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Select the granted requester's data slice for loading into the register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) sel_data = bus.req_data[i*DW +: DW];
    end
  end

  // Accept a word only when enabled, out of reset and the register can take it.
  always_comb begin
    free          = !out_valid_q || bus.out_ready;
    xfer          = clr_n && ce && free && pick_any;
    bus.req_ready = xfer ? pick_gnt : '0;
  end

  // Next control state: fill/drain for IDLE/FULL, burst tracking for LOCK.
  always_comb begin
    state_next = state;
    if (ce) begin
      case (state)
        ST_IDLE, ST_FULL: begin
          if (xfer)               state_next = sel_last ? ST_FULL : ST_LOCK;
          else if (bus.out_ready) state_next = ST_IDLE;
        end
        ST_LOCK: begin
          if (xfer && sel_last)   state_next = ST_FULL;
        end
        default:                  state_next = ST_IDLE;
      endcase
    end
  end

  // Control state and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      last_grant <= LAST_IDX;
    end else if (ce) begin
      state <= state_next;
      if (xfer) last_grant <= pick_idx;
    end
  end

  // Output register: load on transfer, clear valid on a drain with no refill.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (ce) begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_id_q    <= pick_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: randomized and directed stimulus against a behavioural
// model of the arbiter; expected words go into a scoreboard queue that a
// separate monitor drains whenever the output handshake completes.
module tb_port_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic clk = 1'b0;
  logic clr_n;
  logic ce;

  int errors = 0;
  int checks = 0;

  port_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  port_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .ce    (ce),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural model state: output register contents and the rotation point.
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_last;
`ifdef PORT_ARBITER_LOCK_EN
  bit            m_lock;
  int            m_lock_id;
`endif

  int            exp_id[$];
  logic [DW-1:0] exp_data[$];
  int            seen_id[$];
  logic [DW-1:0] seen_data[$];

  logic [DW-1:0] pend_data [NREQ][8];
  bit            pend_last [NREQ][8];
  int            pend_cnt  [NREQ];
  int            pend_head [NREQ];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [NREQ*DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r;
  endfunction

  task automatic reset_model();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_last  = NREQ - 1;
`ifdef PORT_ARBITER_LOCK_EN
    m_lock    = 1'b0;
    m_lock_id = 0;
`endif
    exp_id.delete();
    exp_data.delete();
  endtask

  task automatic clear_seen();
    seen_id.delete();
    seen_data.delete();
  endtask

  // Compare the DUT against the model mid-cycle, then advance the model by
  // what the coming rising edge should do.
  task automatic check_output(output int acc);
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    exp_ready;
    logic [NREQ*DW-1:0] sh;
    bit                 free;
    bit                 use_rr;
    int                 cand;
    v = bus.req_valid;
    check_val("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check_val("out_data", 32'(bus.out_data), 32'(m_data));
    if (m_valid) check_val("out_id", 32'(bus.out_id), 32'(m_id));

    acc    = -1;
    use_rr = 1'b1;
    free   = !m_valid || bus.out_ready;
    if (ce && free) begin
`ifdef PORT_ARBITER_LOCK_EN
      if (m_lock) begin
        use_rr = 1'b0;
        if (bit_of(v, m_lock_id)) acc = m_lock_id;
      end
`endif
      if (use_rr) begin
        for (int k = 1; k <= NREQ; k++) begin
          cand = (m_last + k) % NREQ;
          if (acc < 0 && bit_of(v, cand)) acc = cand;
        end
      end
    end
    exp_ready = '0;
    if (acc >= 0) exp_ready = NREQ'(1) << acc;
    check_val("req_ready", 32'(bus.req_ready), 32'(exp_ready));

    if (ce) begin
      if (acc >= 0) begin
        sh      = bus.req_data >> (acc * DW);
        m_data  = sh[DW-1:0];
        m_valid = 1'b1;
        m_id    = acc;
        m_last  = acc;
        exp_id.push_back(acc);
        exp_data.push_back(m_data);
`ifdef PORT_ARBITER_LOCK_EN
        if (bit_of(bus.req_last, acc)) m_lock = 1'b0;
        else begin
          m_lock    = 1'b1;
          m_lock_id = acc;
        end
`endif
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                                input logic [NREQ-1:0] l, input logic c, input logic r,
                                output int acc);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    ce            = c;
    bus.out_ready = r;
    @(negedge clk);
    check_output(acc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    ce            = 1'b1;
    clr_n         = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data", 32'(bus.out_data), 32'd0);
    check_val("rst_out_id", 32'(bus.out_id), 32'd0);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    reset_model();
    @(posedge clk);
    #1;
    clr_n         = 1'b1;
    bus.req_valid = '0;
  endtask

  task automatic drain();
    int acc;
    int n;
    n = 0;
    while ((exp_id.size() != 0 || m_valid) && n < 20) begin
      apply_stimulus('0, '0, '1, 1'b1, 1'b1, acc);
      n++;
    end
    apply_stimulus('0, '0, '1, 1'b1, 1'b1, acc);
    check_val("drain_empty", 32'(exp_id.size()), 32'd0);
  endtask

  // Scoreboard monitor: every completed output handshake pops one expected word.
  task automatic monitor_loop();
    int            eid;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      if (clr_n && ce && bus.out_valid && bus.out_ready) begin
        if (exp_id.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: actual id=%0d data=%h, required no word", bus.out_id, bus.out_data);
        end else begin
          eid = exp_id.pop_front();
          ed  = exp_data.pop_front();
          check_val("sb_id", 32'(bus.out_id), 32'(eid));
          check_val("sb_data", 32'(bus.out_data), 32'(ed));
        end
        seen_id.push_back(int'(bus.out_id));
        seen_data.push_back(bus.out_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int                 acc;
    int                 n;
    int                 cnt;
    int                 left;
    int                 exp_seq[5];
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    l;
    logic [NREQ*DW-1:0] d;

    clr_n         = 1'b0;
    ce            = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '1;
    bus.out_ready = 1'b0;
    reset_model();
    fork
      monitor_loop();
    join_none
    $display("[TB] port_arbiter bench start");

    // Reset with every requester asking.
    do_reset();

    // Fairness: all requesting, sink always ready.
    clear_seen();
    for (int i = 0; i < 12; i++) apply_stimulus('1, rand_data(), '1, 1'b1, 1'b1, acc);
    drain();
    check_val("fair_count", 32'(seen_id.size()), 32'd12);
    for (int i = 0; i < 12 && i < seen_id.size(); i++)
      check_val("fair_id", 32'(seen_id[i]), 32'(i % 4));

    // Backpressure: one word from requester 2 held for 5 stalled cycles.
    clear_seen();
    d = '0;
    d[2*DW +: DW] = 16'hA5A5;
    apply_stimulus(4'b0100, d, '1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) apply_stimulus(4'b0100, d, '1, 1'b1, 1'b0, acc);
    apply_stimulus('0, '0, '1, 1'b1, 1'b1, acc);
    drain();
    cnt = 0;
    for (int i = 0; i < seen_data.size(); i++) if (seen_data[i] == 16'hA5A5) cnt++;
    check_val("bp_once", 32'(cnt), 32'd1);
    check_val("bp_count", 32'(seen_id.size()), 32'd1);

    // Clock enable: pointer and output frozen while ce is low.
    do_reset();
    clear_seen();
    apply_stimulus(4'b0010, rand_data(), '1, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0001, rand_data(), '1, 1'b0, 1'b1, acc);
    apply_stimulus(4'b1111, rand_data(), '1, 1'b1, 1'b1, acc);
    apply_stimulus(4'b0001, rand_data(), '1, 1'b1, 1'b1, acc);
    drain();
    check_val("ce_count", 32'(seen_id.size()), 32'd3);
    if (seen_id.size() == 3) begin
      check_val("ce_id0", 32'(seen_id[0]), 32'd1);
      check_val("ce_id1", 32'(seen_id[1]), 32'd2);
      check_val("ce_id2", 32'(seen_id[2]), 32'd0);
    end

    // Burst scenario: requester 1 sends 3 words (last on the third), 3 sends 2.
    do_reset();
    clear_seen();
    for (int r = 0; r < NREQ; r++) begin
      pend_cnt[r]  = 0;
      pend_head[r] = 0;
    end
    pend_data[1][0] = 16'h1001; pend_last[1][0] = 1'b0;
    pend_data[1][1] = 16'h1002; pend_last[1][1] = 1'b0;
    pend_data[1][2] = 16'h1003; pend_last[1][2] = 1'b1;
    pend_cnt[1]     = 3;
    pend_data[3][0] = 16'h3001; pend_last[3][0] = 1'b1;
    pend_data[3][1] = 16'h3002; pend_last[3][1] = 1'b1;
    pend_cnt[3]     = 2;
    n    = 0;
    left = 5;
    while (left > 0 && n < 20) begin
      v = '0;
      l = '1;
      d = '0;
      for (int r = 0; r < NREQ; r++) begin
        if (pend_head[r] < pend_cnt[r]) begin
          v[r]          = 1'b1;
          d[r*DW +: DW] = pend_data[r][pend_head[r]];
          l[r]          = pend_last[r][pend_head[r]];
        end
      end
      apply_stimulus(v, d, l, 1'b1, 1'b1, acc);
      if (acc >= 0) begin
        pend_head[acc]++;
        left--;
      end
      n++;
    end
    drain();
`ifdef PORT_ARBITER_LOCK_EN
    exp_seq = '{1, 1, 1, 3, 3};
`else
    exp_seq = '{1, 3, 1, 3, 1};
`endif
    check_val("burst_count", 32'(seen_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_id.size(); i++)
      check_val("burst_id", 32'(seen_id[i]), 32'(exp_seq[i]));

    // Random traffic with random enable, backpressure and burst markers.
    for (int i = 0; i < 400; i++) begin
      v = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      apply_stimulus(v, rand_data(), l, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, acc);
    end

    // Reset while a word is held: it must vanish without being delivered.
    apply_stimulus(4'b1000, rand_data(), '1, 1'b1, 1'b0, acc);
    apply_stimulus(4'b0000, rand_data(), '1, 1'b1, 1'b0, acc);
    do_reset();
    apply_stimulus('0, '0, '1, 1'b1, 1'b1, acc);

    for (int i = 0; i < 100; i++) begin
      v = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      apply_stimulus(v, rand_data(), l, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 16, data width of each requester port and the shared output port.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 clr_n  input  1  asynchronous active-low reset.
REQ-005 ce  input  1  clock enable; when low, no state, pointer or output register changes.
REQ-006 req_valid  input  NREQ  per-requester data-valid.
REQ-007 req_data  input  NREQ*DW  packed requester data; slice i belongs to requester i.
REQ-008 req_last  input  NREQ  per-requester end-of-burst marker, used only under the lock feature.
REQ-009 req_ready  output  NREQ  one-hot or zero; the transfer from requester i occurs when req_valid[i] & req_ready[i].
REQ-010 out_valid  output  1  shared output register holds valid data.
REQ-011 out_data  output  DW  shared output data, registered.
REQ-012 out_id  output  clog2(NREQ)  index of the requester that sourced out_data.
REQ-013 out_ready  input  1  downstream accepts; handshake completes when out_valid & out_ready.

Function
REQ-014 Output register "free" SHALL mean !out_valid | out_ready.
REQ-015 req_ready SHALL be asserted only for the granted requester, and only when ce=1, the output register is free and that requester's req_valid=1.
REQ-016 Grant: round-robin; search starts at (last_grant+1) mod NREQ and wraps; the first requester with req_valid=1 wins.
REQ-017 last_grant SHALL update only on a completed requester transfer, never on idle or stalled cycles.
REQ-018 Latency: data accepted at edge N appears on out_data/out_id with out_valid=1 after edge N (one cycle).
REQ-019 While out_valid=1 and out_ready=0, out_data, out_id and out_valid SHALL hold stable.
REQ-020 Simultaneous drain and fill (out_ready=1, new transfer accepted) SHALL keep out_valid=1 with the new data; throughput is one word per cycle.
REQ-021 Drain with no new transfer SHALL clear out_valid on the next edge; out_data keeps its last value.
REQ-022 With ce=0, out_ready is ignored for state update and req_ready is 0; out_* outputs hold.
REQ-023 Control FSM states: IDLE (register empty), FULL (register holds data), LOCK (only under REQ-029); transitions follow REQ-018..021.
REQ-024 req_valid deasserting before acceptance SHALL be legal; arbitration re-evaluates every cycle.

Reset
REQ-025 clr_n low SHALL immediately force out_valid=0, out_data=0, out_id=0, req_ready=0, FSM=IDLE, last_grant=NREQ-1 (requester 0 highest priority first).
REQ-026 Reset asserted mid-transfer SHALL discard the held word with no partial output.
REQ-027 Deassertion is synchronous to clk via the standard reset-release path; first grant is possible on the first edge after release.

Configuration
REQ-028 Macro PORT_ARBITER_LOCK_EN selects burst locking.
REQ-029 Defined: after a transfer with req_last=0, grant stays on that requester (FSM LOCK) regardless of other requests until a transfer with req_last=1 completes; round-robin then resumes from that requester+1.
REQ-030 Undefined: req_last ignored, LOCK state absent, every word arbitrated independently per REQ-016.

Structure
REQ-031 Shared package port_arbiter_pkg SHALL hold the FSM state enum, default NREQ/DW constants and the id-width function.
REQ-032 Sub-module rr_pick (combinational round-robin picker: request vector plus start index in, one-hot grant plus index out) SHALL be instantiated once.

Verification
REQ-033 Reset: clr_n=0 with all req_valid=1 -> out_valid=0, out_data=0, req_ready=0 asynchronously.
REQ-034 Fairness: req_valid=4'b1111, out_ready=1 constant -> out_id sequence 0,1,2,3,0,... one word per cycle.
REQ-035 Backpressure: requester 2 sends 16'hA5A5, out_ready=0 for 5 cycles -> out_data=16'hA5A5, out_id=2 held stable, req_ready=0 throughout; word appears exactly once.
REQ-036 ce gating: ce=0 for 3 cycles with req_valid=4'b0001 -> no transfer, pointer unchanged; ce=1 -> 1-cycle latency resumes.
REQ-037 Lock (macro defined): requester 1 sends 3 words with req_last=0,0,1 while requester 3 also valid -> out_id=1,1,1 then 3.
REQ-038 Lock (macro undefined): same stimulus -> out_id=1,3,1,3,1.
